// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the wall-clock set controller: state encoding and
// default timing constants derived from the 100 MHz system clock.
package clock_set_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    localparam int CLK_HZ                = 100_000_000;
    localparam int REPEAT_DELAY_DEFAULT  = CLK_HZ / 2;
    localparam int REPEAT_PERIOD_DEFAULT = CLK_HZ / 10;
    localparam int BLINK_HALF_DEFAULT    = CLK_HZ / 4;
    localparam int TIMEOUT_TICKS_DEFAULT = 30;

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Press-edge detector with hold-to-repeat counter. o_strobe fires on the press
// and then at REPEAT_DELAY and every REPEAT_PERIOD while the button stays held.
module btn_repeat
    import clock_set_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    input  logic i_en,
    output logic o_press,
    output logic o_strobe
);

    localparam int CW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0] C_LAST   = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] C_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic          r_btn;
    logic [CW-1:0] r_cnt;
    logic          w_rep;

    // A non-zero count means "armed": only a press seen while enabled starts it.
    assign o_press  = i_btn & ~r_btn;
    assign w_rep    = i_btn & ~o_press & (r_cnt == C_LAST);
    assign o_strobe = i_en & (o_press | w_rep);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_btn <= i_btn;
            if (!i_en || !i_btn) begin
                r_cnt <= '0;
            end else if (o_press) begin
                r_cnt <= CW'(1);
            end else if (r_cnt == C_LAST) begin
                r_cnt <= C_RELOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set sequencer for the seconds/minutes/hours counter chain: forwards
// carries in RUN, turns buttons into advance strobes in SET modes, blinks the field.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT,
    parameter int BLINK_HALF    = BLINK_HALF_DEFAULT,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_wrap,
    input  logic       min_wrap,
    output logic       sec_inc,
    output logic       sec_clr,
    output logic       min_inc,
    output logic       hr_inc,
    output logic       blank_hr,
    output logic       blank_min,
    output logic [1:0] mode
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [TW-1:0] C_TO_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [BW-1:0] C_PH_LAST = BW'(BLINK_HALF - 1);

    state_t        r_state;
    logic          r_mode_btn;
    logic [TW-1:0] r_to;
    logic [BW-1:0] r_ph;
    logic          r_blink;
    logic          r_sec_inc, r_sec_clr, r_min_inc, r_hr_inc;

    logic w_mode_press, w_inc_press, w_any_press;
    logic w_set, w_legal, w_timeout, w_chg, w_rep_en, w_inc_strobe;

    assign w_mode_press = btn_mode & ~r_mode_btn;
    assign w_any_press  = w_mode_press | w_inc_press;
    assign w_set        = (r_state == SET_HR) | (r_state == SET_MIN);
    assign w_legal      = w_set | (r_state == RUN);
    // A press in the timeout cycle restarts the timer instead of leaving.
    assign w_timeout    = w_set & tick_1hz & ~w_any_press & (r_to == C_TO_LAST);
    // Every mode press moves the state, so it alone marks a transition.
    assign w_chg        = w_mode_press | w_timeout | ~w_legal;
    assign w_rep_en     = w_set & ~w_chg;

    btn_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_inc (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_inc),
        .i_en    (w_rep_en),
        .o_press (w_inc_press),
        .o_strobe(w_inc_strobe)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_mode_btn <= 1'b0;
            r_to       <= '0;
            r_ph       <= '0;
            r_blink    <= 1'b0;
            r_sec_inc  <= 1'b0;
            r_sec_clr  <= 1'b0;
            r_min_inc  <= 1'b0;
            r_hr_inc   <= 1'b0;
        end else begin
            r_mode_btn <= btn_mode;
            case (r_state)
                RUN:     if (w_mode_press) r_state <= SET_HR;
                SET_HR:  if (w_mode_press) r_state <= SET_MIN;
                         else if (w_timeout) r_state <= RUN;
                SET_MIN: if (w_mode_press || w_timeout) r_state <= RUN;
                default: r_state <= RUN;
            endcase

            r_sec_inc <= (r_state == RUN) & ~w_chg & tick_1hz;
            r_sec_clr <= (r_state == SET_MIN) & (w_mode_press | w_timeout);
            r_min_inc <= (r_state == RUN) ? sec_wrap : ((r_state == SET_MIN) & w_inc_strobe);
            r_hr_inc  <= (r_state == RUN) ? min_wrap : ((r_state == SET_HR) & w_inc_strobe);

            if (w_chg || w_any_press) begin
                r_to <= '0;
            end else if (w_set && tick_1hz) begin
                r_to <= r_to + 1'b1;
            end

            if (w_chg || w_inc_strobe) begin
                r_ph    <= '0;
                r_blink <= 1'b0;
            end else if (r_ph == C_PH_LAST) begin
                r_ph    <= '0;
                r_blink <= ~r_blink;
            end else begin
                r_ph <= r_ph + 1'b1;
            end
        end
    end

    assign sec_inc   = r_sec_inc;
    assign sec_clr   = r_sec_clr;
    assign min_inc   = r_min_inc;
    assign hr_inc    = r_hr_inc;
    assign blank_hr  = (r_state == SET_HR) & r_blink;
    assign blank_min = (r_state == SET_MIN) & r_blink;
    assign mode      = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random stimulus, all
// checked every cycle against a behavioural model of the set-mode rules.
module tb_clock_set_ctrl;

    localparam int RD = 20;
    localparam int RP = 5;
    localparam int BH = 8;
    localparam int TT = 3;

    logic clk = 1'b0;
    logic reset, tick_1hz, btn_mode, btn_inc, sec_wrap, min_wrap;
    logic sec_inc, sec_clr, min_inc, hr_inc, blank_hr, blank_min;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;

    clock_set_ctrl #(
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .BLINK_HALF   (BH),
        .TIMEOUT_TICKS(TT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_wrap (sec_wrap),
        .min_wrap (min_wrap),
        .sec_inc  (sec_inc),
        .sec_clr  (sec_clr),
        .min_inc  (min_inc),
        .hr_inc   (hr_inc),
        .blank_hr (blank_hr),
        .blank_min(blank_min),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: state number, held-cycle count, ticks since last
    // activity, cycles since the blink phase was restarted.
    int  m_st, m_h, m_tc, m_age;
    bit  m_armed, m_pm, m_pi, model_ok;
    logic e_sec_inc, e_sec_clr, e_min_inc, e_hr_inc, e_bhr, e_bmin;
    logic [1:0] e_mode;

    always @(posedge clk) begin
        bit mp, ip, tout, chg, strobe, in_set;
        int nst;
        if (reset) begin
            m_st = 0; m_h = 0; m_tc = 0; m_age = 0;
            m_armed = 0; m_pm = 0; m_pi = 0;
            {e_sec_inc, e_sec_clr, e_min_inc, e_hr_inc} = 4'b0;
        end else begin
            mp = btn_mode && !m_pm;
            ip = btn_inc && !m_pi;
            in_set = (m_st == 1) || (m_st == 2);
            tout = 0;
            if (in_set) begin
                if (mp || ip) m_tc = 0;
                else if (tick_1hz) begin
                    m_tc++;
                    if (m_tc == TT) tout = 1;
                end
            end
            if (m_st > 2) nst = 0;
            else if (mp) nst = (m_st + 1) % 3;
            else if (tout) nst = 0;
            else nst = m_st;
            chg = (nst != m_st);
            strobe = 0;
            if (!in_set || chg) m_armed = 0;
            else if (ip) begin m_armed = 1; m_h = 1; strobe = 1; end
            else if (btn_inc && m_armed) begin
                m_h++;
                if (m_h >= RD && (m_h - RD) % RP == 0) strobe = 1;
            end else m_armed = 0;
            e_sec_inc = (m_st == 0) && !chg && tick_1hz;
            e_sec_clr = (m_st == 2) && (nst == 0);
            e_min_inc = (m_st == 0) ? sec_wrap : ((m_st == 2) && strobe);
            e_hr_inc  = (m_st == 0) ? min_wrap : ((m_st == 1) && strobe);
            if (chg || strobe) m_age = 0; else m_age++;
            if (chg) m_tc = 0;
            m_st = nst;
            m_pm = btn_mode;
            m_pi = btn_inc;
        end
        e_mode = 2'(m_st);
        e_bhr  = (m_st == 1) && ((m_age / BH) % 2 == 1);
        e_bmin = (m_st == 2) && ((m_age / BH) % 2 == 1);
        model_ok = 1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("sec_inc", sec_inc, e_sec_inc);
            chk("sec_clr", sec_clr, e_sec_clr);
            chk("min_inc", min_inc, e_min_inc);
            chk("hr_inc", hr_inc, e_hr_inc);
            chk("blank_hr", blank_hr, e_bhr);
            chk("blank_min", blank_min, e_bmin);
            chk("mode", mode, e_mode);
        end
    end

    task automatic step(input logic m, input logic i, input logic t, input logic sw, input logic mw);
        btn_mode = m; btn_inc = i; tick_1hz = t; sec_wrap = sw; min_wrap = mw;
        @(negedge clk);
    endtask

    task automatic press_mode();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int n_sec, n_min, n_hr, n_bmin, min_at, n_pos, n_clr;
        int pos[6];
        int exp_pos[6];
        exp_pos = '{1, 20, 25, 30, 35, 40};
        reset = 1'b1;
        btn_mode = 0; btn_inc = 0; tick_1hz = 0; sec_wrap = 0; min_wrap = 0;
        repeat (3) @(negedge clk);
        chk("rst_mode", mode, 0);
        chk("rst_strobes", {sec_inc, sec_clr, min_inc, hr_inc}, 0);
        chk("rst_blank", {blank_hr, blank_min}, 0);
        reset = 1'b0;

        // 1: RUN forwarding
        n_sec = 0; n_min = 0; n_hr = 0; min_at = -1;
        for (int c = 0; c < 60; c++) begin
            step(0, 0, (c % 10) == 0, c == 50, 0);
            n_sec += int'(sec_inc); n_min += int'(min_inc); n_hr += int'(hr_inc);
            if (min_inc) min_at = c;
        end
        chk("t1_sec_inc_count", n_sec, 6);
        chk("t1_min_inc_count", n_min, 1);
        chk("t1_min_inc_cycle", min_at, 50);
        chk("t1_hr_inc_count", n_hr, 0);

        // 2: SET_HR with three single-cycle inc presses, blink phase
        press_mode();
        chk("t2_mode", mode, 1);
        n_sec = 0; n_hr = 0; n_bmin = 0;
        for (int p = 0; p < 3; p++) begin
            step(0, 1, p == 1, 0, 0);
            n_hr += int'(hr_inc); n_sec += int'(sec_inc); n_bmin += int'(blank_min);
            for (int k = 1; k <= ((p == 2) ? 16 : 4); k++) begin
                step(0, 0, k == 2, 0, 0);
                n_hr += int'(hr_inc); n_sec += int'(sec_inc); n_bmin += int'(blank_min);
                if (p == 2 && (k == 7 || k == 8 || k == 15 || k == 16))
                    chk($sformatf("t2_blank_hr_k%0d", k), blank_hr, (k == 8 || k == 15) ? 1 : 0);
            end
        end
        chk("t2_hr_inc_count", n_hr, 3);
        chk("t2_sec_inc_count", n_sec, 0);
        chk("t2_blank_min_count", n_bmin, 0);

        // 3: SET_MIN hold for auto-repeat, min_wrap must not carry
        press_mode();
        chk("t3_mode", mode, 2);
        n_pos = 0; n_hr = 0;
        for (int k = 1; k <= 40; k++) begin
            step(0, 1, 0, 0, k == 10);
            n_hr += int'(hr_inc);
            if (min_inc) begin
                if (n_pos < 6) pos[n_pos] = k;
                n_pos++;
            end
        end
        step(0, 0, 0, 0, 0);
        chk("t3_min_inc_count", n_pos, 6);
        for (int j = 0; j < 6; j++)
            if (j < n_pos) chk($sformatf("t3_repeat_pos%0d", j), pos[j], exp_pos[j]);
        chk("t3_hr_inc_count", n_hr, 0);

        // 4: leave SET_MIN by button
        step(1, 0, 0, 0, 0);
        chk("t4_mode", mode, 0);
        chk("t4_sec_clr", sec_clr, 1);
        step(0, 0, 0, 0, 0);
        chk("t4_sec_clr_single", sec_clr, 0);
        step(0, 0, 1, 0, 0);
        chk("t4_sec_inc_resumes", sec_inc, 1);

        // 5: timeouts from both SET states
        press_mode();
        for (int t = 1; t <= 3; t++) begin
            step(0, 0, 1, 0, 0);
            chk($sformatf("t5_hr_mode_tick%0d", t), mode, (t == 3) ? 0 : 1);
            if (t == 3) chk("t5_hr_no_sec_clr", sec_clr, 0);
            step(0, 0, 0, 0, 0);
        end
        press_mode();
        press_mode();
        n_clr = 0;
        for (int t = 1; t <= 3; t++) begin
            step(0, 0, 1, 0, 0);
            n_clr += int'(sec_clr);
            chk($sformatf("t5_min_mode_tick%0d", t), mode, (t == 3) ? 0 : 2);
            step(0, 0, 0, 0, 0);
            n_clr += int'(sec_clr);
        end
        chk("t5_min_sec_clr_count", n_clr, 1);

        // 6: reset during auto-repeat, no strobe until a fresh press
        press_mode();
        press_mode();
        for (int k = 1; k <= 25; k++) step(0, 1, 0, 0, 0);
        reset = 1'b1;
        step(0, 1, 0, 0, 0);
        chk("t6_rst_mode", mode, 0);
        chk("t6_rst_strobes", {sec_inc, sec_clr, min_inc, hr_inc}, 0);
        chk("t6_rst_blank", {blank_hr, blank_min}, 0);
        reset = 1'b0;
        n_pos = 0;
        for (int k = 0; k < 5; k++) begin step(0, 1, 0, 0, 0); n_pos += int'(min_inc | hr_inc); end
        step(1, 1, 0, 0, 0); n_pos += int'(min_inc | hr_inc);
        step(0, 1, 0, 0, 0); n_pos += int'(min_inc | hr_inc);
        step(1, 1, 0, 0, 0); n_pos += int'(min_inc | hr_inc);
        for (int k = 0; k < 30; k++) begin step(0, 1, 0, 0, 0); n_pos += int'(min_inc | hr_inc); end
        chk("t6_mode_set_min", mode, 2);
        chk("t6_no_stale_strobe", n_pos, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("t6_fresh_press", min_inc, 1);
        step(0, 0, 0, 0, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 599) == 0);
            btn_mode = ($urandom_range(0, 99) < (btn_mode ? 60 : 3));
            btn_inc  = ($urandom_range(0, 99) < (btn_inc ? 96 : 6));
            tick_1hz = ($urandom_range(0, 7) == 0);
            sec_wrap = ($urandom_range(0, 15) == 0);
            min_wrap = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        step(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Sequencing controller for the wall-clock counter chain (seconds, minutes, 12-hour counters).
- RUN mode: forwards the 1 Hz tick and the rollover carries as one-cycle advance strobes.
- SET modes: freezes timekeeping and converts the debounced mode/inc buttons (with auto-repeat) into hour/minute advance strobes.
- Generates display blanking masks that blink the field being set.
- Sits between the button debouncers/prescaler and the counter modules.

Parameters:
- REPEAT_DELAY, 50000000, clk cycles inc must be held before auto-repeat starts (0.5 s at 100 MHz).
- REPEAT_PERIOD, 10000000, clk cycles between auto-repeat strobes.
- BLINK_HALF, 25000000, clk cycles per blink phase (on or off).
- TIMEOUT_TICKS, 30, tick_1hz pulses with no button press before a SET mode returns to RUN.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- tick_1hz, input, 1, one-clk pulse per second from the prescaler.
- btn_mode, input, 1, debounced level, high while pressed.
- btn_inc, input, 1, debounced level, high while pressed.
- sec_wrap, input, 1, seconds-counter rollover pulse.
- min_wrap, input, 1, minutes-counter rollover pulse.
- sec_inc, output, 1, advance seconds counter.
- sec_clr, output, 1, clear seconds counter.
- min_inc, output, 1, advance minutes counter.
- hr_inc, output, 1, advance hours counter.
- blank_hr, output, 1, blank hour digits.
- blank_min, output, 1, blank minute digits.
- mode, output, 2, current state encoding.

Behaviour:
- Clock and reset: clk, reset synchronous active-high. Reset: state=RUN; all strobes 0; blank_hr=blank_min=0; mode=0; edge registers, repeat/blink/timeout counters cleared.
- Strobe outputs: all registered, at most one clk high per event, 1-cycle latency from the causing input.
- Button edges: each button's press is its registered 0->1 transition. Release produces nothing.
- States: RUN=0, SET_HR=1, SET_MIN=2. 3 is illegal and recovers to RUN next cycle.
- btn_mode press transitions: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN.
- Leaving SET_MIN to RUN, by button or timeout: sec_clr=1 for one cycle.
- Timeout transitions: SET_HR->RUN on timeout with no sec_clr. SET_MIN->RUN on timeout with sec_clr.
- RUN:
  - sec_inc=tick_1hz.
  - min_inc=sec_wrap.
  - hr_inc=min_wrap.
  - btn_inc is ignored.
- SET_HR:
  - sec_inc=0 and min_inc=0.
  - Wrap inputs are ignored (no carries).
  - hr_inc=1 on btn_inc press.
- SET_MIN:
  - sec_inc=0 and hr_inc=0.
  - min_wrap is ignored; minute wrap must not advance hours.
  - min_inc=1 on btn_inc press.
- Auto-repeat (SET states only):
  - While btn_inc is held, a repeat counter counts clk cycles.
  - At REPEAT_DELAY cycles after the press, emit an extra strobe, then one every REPEAT_PERIOD cycles.
  - Release, a state change or reset clears the counter.
- Timeout:
  - Counter clears on entry to a SET state and on any button press.
  - It increments on tick_1hz in SET states.
  - Reaching TIMEOUT_TICKS forces RUN.
- Blink:
  - Phase counter toggles a blink bit every BLINK_HALF cycles.
  - Phase resets to visible (bit 0) on every state entry and every inc strobe.
  - blank_hr = (state==SET_HR) and blink bit.
  - blank_min = (state==SET_MIN) and blink bit.
- Simultaneous events:
  - btn_mode and btn_inc pressed in the same cycle: mode wins; no inc strobe.
  - tick_1hz in the same cycle as a RUN->SET_HR transition is dropped.
  - On SET->RUN transition cycles no inc strobes are issued.
- Counter widths: $clog2(param+1). Terminal compares use equality; counters never exceed their terminal value.

Decomposition:
- Shared clock package: state localparams RUN/SET_HR/SET_MIN, and the 100 MHz cycle constants used by the parameter defaults.
- One sub-module, btn_repeat: press edge detect plus hold/auto-repeat counter. Outputs a single strobe and a press flag. Parameterised by REPEAT_DELAY/REPEAT_PERIOD.

Test Plan:
Bench uses REPEAT_DELAY=20, REPEAT_PERIOD=5, BLINK_HALF=8, TIMEOUT_TICKS=3.
1. RUN, tick_1hz every 10 clks, sec_wrap pulse at cycle 50 -> sec_inc each tick 1 clk later; min_inc once at cycle 51; hr_inc never.
2. Press mode, then inc 3 times (1-clk presses) -> state=1; hr_inc exactly 3 pulses; sec_inc stays 0 despite ticks; blank_hr toggles every 8 clks; blank_min=0.
3. In SET_MIN, hold btn_inc for 40 clks -> min_inc at press+1, then press+20, 25, 30, 35, 40 (6 total); injected min_wrap gives hr_inc=0.
4. SET_MIN, press mode -> state=0 next clk; sec_clr single pulse; sec_inc resumes on next tick.
5. SET_HR, no buttons, 3 ticks -> state=0 after third tick; sec_clr=0. Same test in SET_MIN -> sec_clr=1 once.
6. Reset asserted mid auto-repeat in SET_MIN -> next clk state=0, all outputs 0. No strobe until a fresh press after a return to a SET state.
